// File: rtl/board_background_fx.sv
`default_nettype none
// ============================================================================
// Module   : board_background_fx
// Purpose  : Board background layer (rail + felt) with frame-synchronous
//            felt flash effect triggered by game events.
// Revision : 1.0
// ============================================================================
module board_background_fx #(
    parameter int          TOP_OFFSET   = 40,
    parameter int          DOWN_OFFSET  = 440,
    parameter int          LEFT_OFFSET  = 20,
    parameter int          RIGHT_OFFSET = 620,
    parameter int          RAIL_WIDTH   = 16,
    parameter logic [7:0]  BOARD_COLOR  = 8'b00010100,
    parameter logic [7:0]  RAIL_COLOR   = 8'b01100100,
    parameter logic [7:0]  FLASH_COLOR  = 8'hFF,
    parameter int          FLASH_FRAMES = 8,
    parameter int          FLASH_PHASES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [10:0] pixelX,
    input  logic signed [10:0] pixelY,
    input  logic               startOfFrame,
    input  logic               flashTrigger,
    output logic               drawingRequestBoard,
    output logic               drawingRequestRail,
    output logic [7:0]         RGBoutBoard,
    output logic               flashActive
);

    localparam int FRAME_W = $clog2(FLASH_FRAMES + 1);
    localparam int PHASE_W = $clog2(FLASH_PHASES + 1);

    // Bounds widened to 12 bits so negative coordinates compare as outside.
    localparam logic signed [11:0] C_BOX_L  = 12'(LEFT_OFFSET);
    localparam logic signed [11:0] C_BOX_R  = 12'(RIGHT_OFFSET);
    localparam logic signed [11:0] C_BOX_T  = 12'(TOP_OFFSET);
    localparam logic signed [11:0] C_BOX_D  = 12'(DOWN_OFFSET);
    localparam logic signed [11:0] C_FELT_L = 12'(LEFT_OFFSET + RAIL_WIDTH);
    localparam logic signed [11:0] C_FELT_R = 12'(RIGHT_OFFSET - RAIL_WIDTH);
    localparam logic signed [11:0] C_FELT_T = 12'(TOP_OFFSET + RAIL_WIDTH);
    localparam logic signed [11:0] C_FELT_D = 12'(DOWN_OFFSET - RAIL_WIDTH);

    localparam logic [FRAME_W-1:0] C_FRAMES = FRAME_W'(FLASH_FRAMES);
    localparam logic [PHASE_W-1:0] C_PHASES = PHASE_W'(FLASH_PHASES);
    localparam logic [FRAME_W-1:0] C_FRAME_ONE = FRAME_W'(1);
    localparam logic [PHASE_W-1:0] C_PHASE_ONE = PHASE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FLASH_ON  = 2'd1,
        S_FLASH_OFF = 2'd2
    } state_t;

    state_t               state_q;
    logic                 pending_q;
    logic [FRAME_W-1:0]   frame_cnt_q;
    logic [PHASE_W-1:0]   phase_cnt_q;
    logic                 flash_active_q;
    logic                 board_q;
    logic                 rail_q;
    logic [7:0]           rgb_q;
    logic [7:0]           rgb_d;

    logic signed [11:0]   w_x;
    logic signed [11:0]   w_y;
    logic                 w_in_box;
    logic                 w_in_felt;
    logic                 w_in_rail;
    logic                 w_pending;

    assign w_x = {pixelX[10], pixelX};
    assign w_y = {pixelY[10], pixelY};

    assign w_in_box  = (w_x >= C_BOX_L) && (w_x <= C_BOX_R) &&
                       (w_y >= C_BOX_T) && (w_y <= C_BOX_D);
    assign w_in_felt = (w_x >= C_FELT_L) && (w_x <= C_FELT_R) &&
                       (w_y >= C_FELT_T) && (w_y <= C_FELT_D);
    assign w_in_rail = w_in_box && !w_in_felt;

    // A trigger arriving with the frame pulse starts the sequence at that frame.
    assign w_pending = pending_q | flashTrigger;

    always_comb begin
        rgb_d = 8'h00;
        if (w_in_rail) begin
            rgb_d = RAIL_COLOR;
        end else if (w_in_felt) begin
            rgb_d = (state_q == S_FLASH_ON) ? FLASH_COLOR : BOARD_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board_q <= 1'b0;
            rail_q  <= 1'b0;
            rgb_q   <= 8'h00;
        end else begin
            board_q <= w_in_box;
            rail_q  <= w_in_rail;
            rgb_q   <= rgb_d;
        end
    end

    // State only moves on frame start so a frame is never torn mid-scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pending_q      <= 1'b0;
            frame_cnt_q    <= '0;
            phase_cnt_q    <= '0;
            flash_active_q <= 1'b0;
        end else if (startOfFrame) begin
            if (w_pending) begin
                state_q        <= S_FLASH_ON;
                frame_cnt_q    <= C_FRAMES;
                phase_cnt_q    <= C_PHASES;
                pending_q      <= 1'b0;
                flash_active_q <= 1'b1;
            end else if (state_q != S_IDLE) begin
                if (frame_cnt_q > C_FRAME_ONE) begin
                    frame_cnt_q <= frame_cnt_q - C_FRAME_ONE;
                end else if (phase_cnt_q == C_PHASE_ONE) begin
                    state_q        <= S_IDLE;
                    flash_active_q <= 1'b0;
                end else begin
                    state_q     <= (state_q == S_FLASH_ON) ? S_FLASH_OFF : S_FLASH_ON;
                    frame_cnt_q <= C_FRAMES;
                    phase_cnt_q <= phase_cnt_q - C_PHASE_ONE;
                end
            end
        end else if (flashTrigger) begin
            pending_q <= 1'b1;
        end
    end

    assign drawingRequestBoard = board_q;
    assign drawingRequestRail  = rail_q;
    assign RGBoutBoard         = rgb_q;
    assign flashActive         = flash_active_q;

endmodule
`default_nettype wire

// File: tb/tb_board_background_fx.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_background_fx
// Purpose  : Scoreboard bench for board_background_fx (regions + flash FSM).
// Revision : 1.0
// ============================================================================
module tb_board_background_fx;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic               startOfFrame;
    logic               flashTrigger;
    logic               drawingRequestBoard;
    logic               drawingRequestRail;
    logic [7:0]         RGBoutBoard;
    logic               flashActive;

    always #5 clk = ~clk;

    board_background_fx dut (
        .clk                 (clk),
        .reset               (reset),
        .pixelX              (pixelX),
        .pixelY              (pixelY),
        .startOfFrame        (startOfFrame),
        .flashTrigger        (flashTrigger),
        .drawingRequestBoard (drawingRequestBoard),
        .drawingRequestRail  (drawingRequestRail),
        .RGBoutBoard         (RGBoutBoard),
        .flashActive         (flashActive)
    );

    typedef struct packed {
        logic       board;
        logic       rail;
        logic [7:0] rgb;
        logic       active;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: pending flag and 1-based frame index inside a sequence.
    bit   m_pending = 1'b0;
    int   m_frame   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // 0 = outside, 1 = rail, 2 = felt, for the default geometry.
    function automatic int region(input int x, input int y);
        if (x < 20 || x > 620 || y < 40 || y > 440) return 0;
        if (x < 36 || x > 604 || y < 56 || y > 424) return 1;
        return 2;
    endfunction

    function automatic bit model_flash_on();
        return (m_frame != 0) && ((((m_frame - 1) / 8) % 2) == 0);
    endfunction

    task automatic step(input int x, input int y, input bit sof, input bit trig, input bit rst);
        exp_t e;
        exp_t o;
        int   r;
        @(negedge clk);
        pixelX       = 11'(x);
        pixelY       = 11'(y);
        startOfFrame = sof;
        flashTrigger = trig;
        reset        = rst;
        r = region(x, y);
        if (rst) begin
            e         = '0;
            m_pending = 1'b0;
            m_frame   = 0;
        end else begin
            e.board = (r != 0);
            e.rail  = (r == 1);
            e.rgb   = (r == 1) ? 8'h64 : (r == 2) ? (model_flash_on() ? 8'hFF : 8'h14) : 8'h00;
            if (sof) begin
                if (m_pending || trig) begin
                    m_frame   = 1;
                    m_pending = 1'b0;
                end else if (m_frame != 0) begin
                    m_frame++;
                    if (m_frame > 48) m_frame = 0;
                end
            end else if (trig) begin
                m_pending = 1'b1;
            end
            e.active = (m_frame != 0);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk($sformatf("board(%0d,%0d)", x, y), 32'(drawingRequestBoard), 32'(o.board));
        chk($sformatf("rail(%0d,%0d)", x, y),  32'(drawingRequestRail),  32'(o.rail));
        chk($sformatf("rgb(%0d,%0d)f%0d", x, y, m_frame), 32'(RGBoutBoard), 32'(o.rgb));
        chk($sformatf("active f%0d", m_frame), 32'(flashActive), 32'(o.active));
    endtask

    // One frame: frame pulse, felt pixel, rail pixel (optional trigger), felt pixel.
    task automatic frame(input bit trig_sof, input bit trig_mid);
        step(0, 0, 1'b1, trig_sof, 1'b0);
        step(320, 240, 1'b0, 1'b0, 1'b0);
        step(25, 100, 1'b0, trig_mid, 1'b0);
        step(320, 240, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        pixelX       = '0;
        pixelY       = '0;
        startOfFrame = 1'b0;
        flashTrigger = 1'b0;

        // Reset state
        step(320, 240, 1'b0, 1'b0, 1'b1);
        step(320, 240, 1'b0, 1'b0, 1'b1);

        // Region sweep including box and felt edges and a negative column
        step(0, 0, 1'b0, 1'b0, 1'b0);
        step(20, 40, 1'b0, 1'b0, 1'b0);
        step(35, 55, 1'b0, 1'b0, 1'b0);
        step(36, 56, 1'b0, 1'b0, 1'b0);
        step(620, 440, 1'b0, 1'b0, 1'b0);
        step(621, 440, 1'b0, 1'b0, 1'b0);
        step(-1, 100, 1'b0, 1'b0, 1'b0);
        step(604, 424, 1'b0, 1'b0, 1'b0);
        step(605, 300, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0);

        // Mid-frame trigger: pending only until the next frame start
        step(320, 240, 1'b0, 1'b1, 1'b0);
        step(320, 240, 1'b0, 1'b0, 1'b0);
        step(25, 100, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 51; f++) frame(1'b0, 1'b0);

        // Retrigger during frame 20 restarts a full sequence
        frame(1'b1, 1'b0);
        for (int f = 2; f < 20; f++) frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        for (int f = 0; f < 51; f++) frame(1'b0, 1'b0);

        // Double trigger while pending, then coincident trigger with frame start
        step(320, 240, 1'b0, 1'b1, 1'b0);
        step(320, 240, 1'b0, 1'b1, 1'b0);
        for (int f = 0; f < 50; f++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        for (int f = 0; f < 50; f++) frame(1'b0, 1'b0);

        // Reset during FLASH_ON aborts the sequence
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        step(320, 240, 1'b0, 1'b0, 1'b1);
        step(320, 240, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) frame(1'b0, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
